bsg_manycore_host_pkt_bridge: RTL and testbench

Host-side bridge feeding the manycore loader I/O link (the x=0 north I/O port).
- Request path: gathers 32-bit host words into full-width request packets and launches them under credit-based flow control.
- Response path: splits incoming full-width response packets back into 32-bit host words.
- Sits between the host FIFO interface and the loader link endpoint.

---
 rtl/bsg_manycore_host_pkt_bridge.sv | 100 ++++++++++
 tb/tb_bsg_manycore_host_pkt_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_host_pkt_bridge.sv
// bsg_manycore_host_pkt_bridge: packs host words into credit-limited request packets and unpacks response packets into host words
module bsg_manycore_host_pkt_bridge #(
    parameter int packet_width_p = 128,
    parameter int resp_width_p = 128,
    parameter int max_out_credits_p = 16,
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       host_req_v_i,
    input  logic [31:0]                host_req_data_i,
    output logic                       host_req_ready_o,
    output logic                       pkt_v_o,
    output logic [packet_width_p-1:0]  pkt_data_o,
    input  logic                       pkt_ready_i,
    input  logic                       credit_return_i,
    input  logic                       resp_v_i,
    input  logic [resp_width_p-1:0]    resp_data_i,
    output logic                       resp_ready_o,
    output logic                       host_resp_v_o,
    output logic [31:0]                host_resp_data_o,
    input  logic                       host_resp_ready_i,
    output logic [credit_width_lp-1:0] credits_o,
    output logic                       credit_overflow_o,
    output logic                       idle_o
);
    localparam int n_lp = packet_width_p / 32;
    localparam int m_lp = resp_width_p / 32;
    localparam int kw_lp = n_lp > 1 ? $clog2(n_lp) : 1;
    localparam int jw_lp = m_lp > 1 ? $clog2(m_lp) : 1;
    localparam logic [kw_lp-1:0] k_last = kw_lp'(n_lp - 1);
    localparam logic [jw_lp-1:0] j_last = jw_lp'(m_lp - 1);
    localparam logic [credit_width_lp-1:0] credit_max = credit_width_lp'(max_out_credits_p);

    typedef enum logic {COLLECT, SEND} req_state_e;
    typedef enum logic {IDLE, DRAIN} resp_state_e;

    req_state_e              req_state;
    resp_state_e             resp_state;
    logic [kw_lp-1:0]        k;
    logic [jw_lp-1:0]        j;
    logic [resp_width_p-1:0] resp_q;
    logic                    send;

    // pkt_v_o comes only from registered state, never from pkt_ready_i
    assign host_req_ready_o = req_state == COLLECT;
    assign pkt_v_o          = req_state == SEND && credits_o != '0;
    assign send             = pkt_v_o & pkt_ready_i;
    assign resp_ready_o     = resp_state == IDLE;
    assign host_resp_v_o    = resp_state == DRAIN;
    assign host_resp_data_o = resp_q[32*j +: 32];
    assign idle_o           = req_state == COLLECT && k == '0 && credits_o == credit_max && resp_state == IDLE;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_state  <= COLLECT;
            k          <= '0;
            pkt_data_o <= '0;
        end else if (req_state == COLLECT) begin
            if (host_req_v_i) begin
                pkt_data_o[32*k +: 32] <= host_req_data_i;
                k         <= k == k_last ? '0 : k + 1'b1;
                req_state <= k == k_last ? SEND : COLLECT;
            end
        end else if (send) begin
            req_state <= COLLECT;
            k         <= '0;
        end
    end

    // an unmatched return at full count is a protocol error: hold count, flag sticky
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_o         <= credit_max;
            credit_overflow_o <= 1'b0;
        end else if (credit_return_i && !send) begin
            if (credits_o == credit_max) credit_overflow_o <= 1'b1;
            else credits_o <= credits_o + 1'b1;
        end else if (send && !credit_return_i) begin
            credits_o <= credits_o - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_state <= IDLE;
            j          <= '0;
            resp_q     <= '0;
        end else if (resp_state == IDLE) begin
            if (resp_v_i) begin
                resp_q     <= resp_data_i;
                j          <= '0;
                resp_state <= DRAIN;
            end
        end else if (host_resp_ready_i) begin
            j          <= j == j_last ? '0 : j + 1'b1;
            resp_state <= j == j_last ? IDLE : DRAIN;
        end
    end
endmodule

// File: tb/tb_bsg_manycore_host_pkt_bridge.sv
// tb_bsg_manycore_host_pkt_bridge: directed scenarios plus a randomized run against a queue-based reference model
module tb_bsg_manycore_host_pkt_bridge;
    localparam int PW = 128;
    localparam int RW = 128;
    localparam int MC = 16;
    localparam int CW = 5;

    logic          clk = 0;
    logic          reset_n = 0;
    logic          host_req_v = 0;
    logic [31:0]   host_req_data = 0;
    logic          host_req_ready;
    logic          pkt_v;
    logic [PW-1:0] pkt_data;
    logic          pkt_ready = 0;
    logic          credit_return = 0;
    logic          resp_v = 0;
    logic [RW-1:0] resp_data = 0;
    logic          resp_ready;
    logic          host_resp_v;
    logic [31:0]   host_resp_data;
    logic          host_resp_ready = 0;
    logic [CW-1:0] credits;
    logic          credit_overflow;
    logic          idle;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bsg_manycore_host_pkt_bridge #(.packet_width_p(PW), .resp_width_p(RW), .max_out_credits_p(MC)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .host_req_v_i(host_req_v), .host_req_data_i(host_req_data), .host_req_ready_o(host_req_ready),
        .pkt_v_o(pkt_v), .pkt_data_o(pkt_data), .pkt_ready_i(pkt_ready), .credit_return_i(credit_return),
        .resp_v_i(resp_v), .resp_data_i(resp_data), .resp_ready_o(resp_ready),
        .host_resp_v_o(host_resp_v), .host_resp_data_o(host_resp_data), .host_resp_ready_i(host_resp_ready),
        .credits_o(credits), .credit_overflow_o(credit_overflow), .idle_o(idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        host_req_v = 0; pkt_ready = 0; credit_return = 0; resp_v = 0; host_resp_ready = 0;
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        tick();
    endtask

    task automatic load_pkt(input logic [PW-1:0] p);
        for (int i = 0; i < PW / 32; i++) begin
            host_req_v = 1;
            host_req_data = p[32*i +: 32];
            tick();
        end
        host_req_v = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pkt_v !== 1'b0) begin failures++; $display("FAIL reset_pkt_v got=%b exp=0", pkt_v); end
        checks++; if (pkt_data !== '0) begin failures++; $display("FAIL reset_pkt_data got=%h exp=0", pkt_data); end
        checks++; if (credits !== CW'(MC)) begin failures++; $display("FAIL reset_credits got=%0d exp=%0d", credits, MC); end
        checks++; if (credit_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", credit_overflow); end
        checks++; if (host_resp_v !== 1'b0) begin failures++; $display("FAIL reset_host_resp_v got=%b exp=0", host_resp_v); end
        checks++; if (resp_ready !== 1'b1) begin failures++; $display("FAIL reset_resp_ready got=%b exp=1", resp_ready); end
        checks++; if (host_req_ready !== 1'b1) begin failures++; $display("FAIL reset_host_req_ready got=%b exp=1", host_req_ready); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    endtask

    task automatic test_packet();
        logic [PW-1:0] exp;
        exp = 128'h44444444_33333333_22222222_11111111;
        do_reset();
        pkt_ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (host_req_ready !== 1'b1) begin failures++; $display("FAIL pkt_ready_collect w%0d got=%b exp=1", i, host_req_ready); end
            checks++; if (pkt_v !== 1'b0) begin failures++; $display("FAIL pkt_v_early w%0d got=%b exp=0", i, pkt_v); end
            host_req_v = 1;
            host_req_data = exp[32*i +: 32];
            tick();
        end
        host_req_v = 0;
        checks++; if (pkt_v !== 1'b1) begin failures++; $display("FAIL pkt_v_send got=%b exp=1", pkt_v); end
        checks++; if (pkt_data !== exp) begin failures++; $display("FAIL pkt_data got=%h exp=%h", pkt_data, exp); end
        checks++; if (host_req_ready !== 1'b0) begin failures++; $display("FAIL pkt_req_ready_send got=%b exp=0", host_req_ready); end
        checks++; if (credits !== 5'd16) begin failures++; $display("FAIL pkt_credits_pre got=%0d exp=16", credits); end
        tick();
        checks++; if (credits !== 5'd15) begin failures++; $display("FAIL pkt_credits_post got=%0d exp=15", credits); end
        checks++; if (pkt_v !== 1'b0 || host_req_ready !== 1'b1) begin failures++; $display("FAIL pkt_return_collect got v=%b rdy=%b exp v=0 rdy=1", pkt_v, host_req_ready); end
        pkt_ready = 0;
    endtask

    task automatic test_credit_exhaust();
        logic [PW-1:0] p;
        do_reset();
        pkt_ready = 1;
        for (int n = 0; n < MC; n++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            load_pkt(p);
            checks++; if (pkt_v !== 1'b1 || pkt_data !== p) begin failures++; $display("FAIL exh_pkt%0d got v=%b d=%h exp v=1 d=%h", n, pkt_v, pkt_data, p); end
            tick();
        end
        checks++; if (credits !== '0) begin failures++; $display("FAIL exh_credits_zero got=%0d exp=0", credits); end
        p = {$urandom, $urandom, $urandom, $urandom};
        load_pkt(p);
        for (int c = 0; c < 4; c++) begin
            checks++; if (pkt_v !== 1'b0 || pkt_data !== p || host_req_ready !== 1'b0) begin
                failures++; $display("FAIL exh_held c%0d got v=%b rdy=%b d=%h exp v=0 rdy=0 d=%h", c, pkt_v, host_req_ready, pkt_data, p);
            end
            tick();
        end
        credit_return = 1;
        tick();
        credit_return = 0;
        checks++; if (pkt_v !== 1'b1 || credits !== 5'd1) begin failures++; $display("FAIL exh_after_return got v=%b cr=%0d exp v=1 cr=1", pkt_v, credits); end
        tick();
        checks++; if (credits !== '0 || host_req_ready !== 1'b1) begin failures++; $display("FAIL exh_after_send got cr=%0d rdy=%b exp cr=0 rdy=1", credits, host_req_ready); end
        pkt_ready = 0;
    endtask

    task automatic test_credit_same_cycle();
        do_reset();
        pkt_ready = 1;
        for (int n = 0; n < MC - 5; n++) begin
            load_pkt({$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        checks++; if (credits !== 5'd5) begin failures++; $display("FAIL same_pre got=%0d exp=5", credits); end
        load_pkt({$urandom, $urandom, $urandom, $urandom});
        credit_return = 1;
        tick();
        credit_return = 0;
        checks++; if (credits !== 5'd5 || credit_overflow !== 1'b0) begin failures++; $display("FAIL same_cycle got cr=%0d ovf=%b exp cr=5 ovf=0", credits, credit_overflow); end
        pkt_ready = 0;
        do_reset();
        credit_return = 1;
        tick();
        credit_return = 0;
        checks++; if (credit_overflow !== 1'b1 || credits !== 5'd16) begin failures++; $display("FAIL overflow_set got ovf=%b cr=%0d exp ovf=1 cr=16", credit_overflow, credits); end
        repeat (5) tick();
        checks++; if (credit_overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", credit_overflow); end
    endtask

    task automatic test_resp();
        logic [RW-1:0] rd;
        int pat[5] = '{1, 0, 1, 1, 1};
        int idx;
        rd = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        do_reset();
        resp_data = rd;
        resp_v = 1;
        tick();
        resp_v = 0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            host_resp_ready = pat[c][0];
            checks++; if (host_resp_v !== 1'b1 || host_resp_data !== rd[32*idx +: 32] || resp_ready !== 1'b0) begin
                failures++; $display("FAIL resp_c%0d got v=%b d=%h rr=%b exp v=1 d=%h rr=0", c, host_resp_v, host_resp_data, resp_ready, rd[32*idx +: 32]);
            end
            tick();
            idx += pat[c];
        end
        host_resp_ready = 0;
        checks++; if (host_resp_v !== 1'b0 || resp_ready !== 1'b1) begin failures++; $display("FAIL resp_end got v=%b rr=%b exp v=0 rr=1", host_resp_v, resp_ready); end
    endtask

    task automatic test_mid_reset();
        logic [PW-1:0] p;
        do_reset();
        resp_data = {$urandom, $urandom, $urandom, $urandom};
        resp_v = 1;
        host_req_v = 1; host_req_data = 32'hA5A5A5A5;
        tick();
        resp_v = 0;
        host_resp_ready = 1;
        host_req_data = 32'h5A5A5A5A;
        tick();
        host_req_v = 0;
        host_resp_ready = 0;
        reset_n = 0;
        #1;
        checks++; if (pkt_data !== '0 || pkt_v !== 1'b0 || host_req_ready !== 1'b1) begin failures++; $display("FAIL midrst_req got d=%h v=%b rdy=%b exp 0/0/1", pkt_data, pkt_v, host_req_ready); end
        checks++; if (host_resp_v !== 1'b0 || resp_ready !== 1'b1 || credits !== 5'd16 || idle !== 1'b1) begin
            failures++; $display("FAIL midrst_resp got hv=%b rr=%b cr=%0d idle=%b exp 0/1/16/1", host_resp_v, resp_ready, credits, idle);
        end
        tick();
        reset_n = 1;
        tick();
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle); end
        p = {$urandom, $urandom, $urandom, $urandom};
        load_pkt(p);
        checks++; if (pkt_data !== p || pkt_v !== 1'b1) begin failures++; $display("FAIL midrst_newpkt got v=%b d=%h exp v=1 d=%h", pkt_v, pkt_data, p); end
    endtask

    task automatic test_random();
        logic [PW-1:0] m_pkt;
        logic [31:0]   rq[$];
        int            m_k, m_cred;
        bit            m_pend, m_send;
        do_reset();
        m_pkt = '0; m_k = 0; m_cred = MC; m_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            checks++; if (host_req_ready !== !m_pend) begin failures++; $display("FAIL rnd_req_ready c%0d got=%b exp=%b", c, host_req_ready, !m_pend); end
            checks++; if (pkt_v !== (m_pend && m_cred > 0)) begin failures++; $display("FAIL rnd_pkt_v c%0d got=%b exp=%b", c, pkt_v, m_pend && m_cred > 0); end
            checks++; if (pkt_data !== m_pkt) begin failures++; $display("FAIL rnd_pkt_data c%0d got=%h exp=%h", c, pkt_data, m_pkt); end
            checks++; if (credits !== CW'(m_cred)) begin failures++; $display("FAIL rnd_credits c%0d got=%0d exp=%0d", c, credits, m_cred); end
            checks++; if (host_resp_v !== (rq.size() > 0) || resp_ready !== (rq.size() == 0)) begin
                failures++; $display("FAIL rnd_resp_hs c%0d got v=%b rr=%b exp v=%b", c, host_resp_v, resp_ready, rq.size() > 0);
            end
            if (rq.size() > 0) begin
                checks++; if (host_resp_data !== rq[0]) begin failures++; $display("FAIL rnd_resp_data c%0d got=%h exp=%h", c, host_resp_data, rq[0]); end
            end
            checks++; if (idle !== (!m_pend && m_k == 0 && m_cred == MC && rq.size() == 0) || credit_overflow !== 1'b0) begin
                failures++; $display("FAIL rnd_idle c%0d got idle=%b ovf=%b", c, idle, credit_overflow);
            end
            host_req_v = 1'($urandom_range(0, 1));
            host_req_data = $urandom;
            pkt_ready = $urandom_range(0, 3) != 0;
            credit_return = m_cred < MC && $urandom_range(0, 2) == 0;
            resp_v = $urandom_range(0, 3) == 0;
            resp_data = {$urandom, $urandom, $urandom, $urandom};
            host_resp_ready = 1'($urandom_range(0, 1));
            m_send = m_pend && m_cred > 0 && pkt_ready;
            if (!m_pend && host_req_v) begin
                m_pkt[32*m_k +: 32] = host_req_data;
                m_k++;
                if (m_k == PW / 32) begin m_pend = 1; m_k = 0; end
            end else if (m_send) m_pend = 0;
            if (credit_return && !m_send) m_cred++;
            else if (m_send && !credit_return) m_cred--;
            if (rq.size() == 0) begin
                if (resp_v) for (int i = 0; i < RW / 32; i++) rq.push_back(resp_data[32*i +: 32]);
            end else if (host_resp_ready) void'(rq.pop_front());
            tick();
        end
        host_req_v = 0; pkt_ready = 0; credit_return = 0; resp_v = 0; host_resp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_packet();
        test_credit_exhaust();
        test_credit_same_cycle();
        test_resp();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
